bus_bridge: RTL and testbench
=============================

// Module: bus_bridge
// PURPOSE
//  Responder end of the CPU data bus (Bus_addr/Bus_wen/Bus_wdata -> Bus_rdata). Decodes each MEM-stage access
//  to DRAM or to on-board peripheral registers. Hosts the peripheral state: LED latch, switch/button
//  synchronisers, prescaled 32-bit timer, and an 8-digit multiplexed 7-segment scanner.
//  Reads are combinational, because the CPU samples Bus_rdata into MEM_WB on the same edge.
// PARAMETERS
//  SCAN_DIV      20000  cpu_clk cycles per displayed digit (>=1)
//  TDIV_RST      0      reset value of timer prescaler reload register TDIV
// PORTS
//  cpu_clk     in   1   system clock, all state on rising edge
//  cpu_rst     in   1   asynchronous, active-high reset
//  Bus_addr    in   32  byte address from CPU MEM stage
//  Bus_wen     in   1   write strobe, one cycle per store
//  Bus_wdata   in   32  store data
//  Bus_rdata   out  32  load data, combinational from Bus_addr
//  dram_addr   out  14  DRAM word address = Bus_addr[15:2]
//  dram_we     out  1   DRAM write enable
//  dram_wdata  out  32  = Bus_wdata
//  dram_rdata  in   32  DRAM async read data
//  sw          in   24  board switches (asynchronous)
//  btn         in   5   board buttons (asynchronous)
//  led         out  24  LED drive, registered
//  dig_en      out  8   digit enables, active low, one-hot-zero
//  dig_seg     out  8   {a,b,c,d,e,f,g,dp} segments, active low
// BEHAVIOUR
//  - Decode: periph = (Bus_addr[31:12]==20'hFFFFF); dram_we = Bus_wen & ~periph; DRAM never written for periph.
//  - Register map (offset = Bus_addr[11:0]):
//    0x000 DIG  rw  32-bit display value, nibble i -> digit i
//    0x020 TMR  rw  timer count; write loads the value
//    0x024 TDIV rw  prescaler reload
//    0x060 LED  rw  bits[23:0]; read returns {8'b0,led}
//    0x070 SW   ro  {8'b0,sw_sync}; write ignored
//    0x078 BTN  ro  {27'b0,btn_sync}; write ignored
//    Other periph offsets read 32'h0, and writes to them are ignored.
//  - Bus_rdata = periph ? selected register : dram_rdata. Pure combinational, zero latency.
//  - Writes take effect on the rising edge where Bus_wen=1. A read of the same register in the next cycle returns the new value.
//  - sw/btn: 2-flop synchronisers, reset 0. Bus reads see an input change 2 edges later.
//  - Timer prescaler:
//    pre counts 0..TDIV. On the edge where pre==TDIV: pre<=0 and TMR<=TMR+1, wrapping 32'hFFFFFFFF->0.
//    TDIV=0 gives an increment every cycle.
//    A TMR write loads wdata and clears pre. The write wins over a same-cycle increment.
//    A TDIV write loads wdata and clears pre. The TMR value is unchanged.
//  - Scanner:
//    scnt counts 0..SCAN_DIV-1. On terminal count: scnt<=0 and idx<=idx+1 (3-bit, 7->0).
//    dig_en = ~(8'b1<<idx).
//    dig_seg = hex7seg(DIG[4*idx+:4]) with dp=1 (off).
//    Codes: 0:03 1:9F 2:25 3:0D 4:99 5:49 6:41 7:1F 8:01 9:09 A:11 b:C1 C:63 d:85 E:61 F:71.
//  - Reset values: DIG=0, TMR=0, pre=0, TDIV=TDIV_RST, led=0, sync flops=0, scnt=0, idx=0.
//    Hence dig_en=8'hFE and dig_seg=8'h03 during reset.
//  - Reset mid-operation: all state clears immediately (async), independent of cpu_clk.
//    The first count after release occurs on the first edge with cpu_rst=0.
// TESTING
//  1 Store Bus_addr=0x0000_0010 wdata=0xDEADBEEF -> dram_we=1, dram_addr=14'h4; periph regs unchanged.
//  2 Store 0xFFFF_F060 <- 0x00A5A5A5 -> led=24'hA5A5A5 after edge; load same addr -> Bus_rdata=0x00A5A5A5.
//    Store 0xFFFF_F060 -> dram_we=0.
//  3 sw=24'h123456 held -> loads of 0xFFFF_F070 return 0 for 2 edges, then 0x00123456.
//    A load of 0xFFFF_F0FC returns 0.
//  4 TDIV=3, TMR written 0xFFFF_FFFE -> TMR=0xFFFF_FFFF after 4 edges and 0 after 8.
//    A TMR write coinciding with a tick leaves exactly wdata.
//  5 SCAN_DIV=2, DIG=0x0000_00A1 -> dig_en/seg: FE/9F for 2 cycles, FD/11, FB/03 ... 7F/03, then FE/9F.
//  6 Assert cpu_rst mid-scan with TMR counting -> without a clock edge: led=0, dig_en=FE, dig_seg=03.
//    A TMR read after release returns 0.

Source files
------------

// File: rtl/bus_bridge.sv
// rtl/bus_bridge.sv - CPU data-bus responder: DRAM/peripheral decode, LED, sync inputs, timer, 7-seg scanner
module bus_bridge #(
    parameter int          SCAN_DIV = 20000,
    parameter logic [31:0] TDIV_RST = 32'h0
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] Bus_addr,
    input  logic        Bus_wen,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] Bus_rdata,
    output logic [13:0] dram_addr,
    output logic        dram_we,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    input  logic [4:0]  btn,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);

    localparam logic [11:0] OFF_DIG  = 12'h000;
    localparam logic [11:0] OFF_TMR  = 12'h020;
    localparam logic [11:0] OFF_TDIV = 12'h024;
    localparam logic [11:0] OFF_LED  = 12'h060;
    localparam logic [11:0] OFF_SW   = 12'h070;
    localparam logic [11:0] OFF_BTN  = 12'h078;
    localparam logic [31:0] SCAN_LAST = 32'(SCAN_DIV - 1);

    logic        periph;
    logic [11:0] off;
    logic        wr_dig, wr_tmr, wr_tdiv, wr_led;

    logic [31:0] dig_val;
    logic [31:0] tmr;
    logic [31:0] tdiv;
    logic [31:0] pre;
    logic [23:0] sw_meta, sw_sync;
    logic [4:0]  btn_meta, btn_sync;
    logic [31:0] scnt;
    logic [2:0]  idx;
    logic [3:0]  cur_nib;

    assign periph     = (Bus_addr[31:12] == 20'hFFFFF);
    assign off        = Bus_addr[11:0];
    assign dram_addr  = Bus_addr[15:2];
    assign dram_we    = Bus_wen & ~periph;
    assign dram_wdata = Bus_wdata;

    assign wr_dig  = Bus_wen & periph & (off == OFF_DIG);
    assign wr_tmr  = Bus_wen & periph & (off == OFF_TMR);
    assign wr_tdiv = Bus_wen & periph & (off == OFF_TDIV);
    assign wr_led  = Bus_wen & periph & (off == OFF_LED);

    // Load data: peripheral register mux, otherwise DRAM; purely combinational
    always_comb begin
        Bus_rdata = dram_rdata;
        if (periph) begin
            case (off)
                OFF_DIG:  Bus_rdata = dig_val;
                OFF_TMR:  Bus_rdata = tmr;
                OFF_TDIV: Bus_rdata = tdiv;
                OFF_LED:  Bus_rdata = {8'b0, led};
                OFF_SW:   Bus_rdata = {8'b0, sw_sync};
                OFF_BTN:  Bus_rdata = {27'b0, btn_sync};
                default:  Bus_rdata = 32'h0;
            endcase
        end
    end

    // Writable display and LED registers
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            dig_val <= 32'h0;
            led     <= 24'h0;
        end else begin
            if (wr_dig) dig_val <= Bus_wdata;
            if (wr_led) led     <= Bus_wdata[23:0];
        end
    end

    // Two-flop synchronisers for the asynchronous board inputs
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            sw_meta  <= 24'h0;
            sw_sync  <= 24'h0;
            btn_meta <= 5'h0;
            btn_sync <= 5'h0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            btn_meta <= btn;
            btn_sync <= btn_meta;
        end
    end

    // Prescaled timer; bus writes take priority over a same-edge tick
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            tmr  <= 32'h0;
            tdiv <= TDIV_RST;
            pre  <= 32'h0;
        end else if (wr_tmr) begin
            tmr <= Bus_wdata;
            pre <= 32'h0;
        end else if (wr_tdiv) begin
            tdiv <= Bus_wdata;
            pre  <= 32'h0;
        end else if (pre == tdiv) begin
            pre <= 32'h0;
            tmr <= tmr + 32'h1;
        end else begin
            pre <= pre + 32'h1;
        end
    end

    // Digit scan: dwell SCAN_DIV cycles per digit, then advance the 3-bit index
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            scnt <= 32'h0;
            idx  <= 3'd0;
        end else if (scnt == SCAN_LAST) begin
            scnt <= 32'h0;
            idx  <= idx + 3'd1;
        end else begin
            scnt <= scnt + 32'h1;
        end
    end

    assign cur_nib = dig_val[{idx, 2'b00} +: 4];
    assign dig_en  = ~(8'b1 << idx);

    // Hex to active-low {a..g,dp} pattern, decimal point held off
    always_comb begin
        dig_seg = 8'hFF;
        case (cur_nib)
            4'h0: dig_seg = 8'h03;
            4'h1: dig_seg = 8'h9F;
            4'h2: dig_seg = 8'h25;
            4'h3: dig_seg = 8'h0D;
            4'h4: dig_seg = 8'h99;
            4'h5: dig_seg = 8'h49;
            4'h6: dig_seg = 8'h41;
            4'h7: dig_seg = 8'h1F;
            4'h8: dig_seg = 8'h01;
            4'h9: dig_seg = 8'h09;
            4'hA: dig_seg = 8'h11;
            4'hB: dig_seg = 8'hC1;
            4'hC: dig_seg = 8'h63;
            4'hD: dig_seg = 8'h85;
            4'hE: dig_seg = 8'h61;
            4'hF: dig_seg = 8'h71;
            default: dig_seg = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_bus_bridge.sv
// tb/tb_bus_bridge.sv - scoreboard bench for bus_bridge
module tb_bus_bridge;

    localparam logic [31:0] A_DIG  = 32'hFFFF_F000;
    localparam logic [31:0] A_TMR  = 32'hFFFF_F020;
    localparam logic [31:0] A_TDIV = 32'hFFFF_F024;
    localparam logic [31:0] A_LED  = 32'hFFFF_F060;
    localparam logic [31:0] A_SW   = 32'hFFFF_F070;
    localparam logic [31:0] A_BTN  = 32'hFFFF_F078;
    localparam logic [31:0] A_UNM  = 32'hFFFF_F0FC;
    localparam logic [31:0] DRAM_Q = 32'hCAFE_F00D;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic [31:0] Bus_addr = 32'h0;
    logic        Bus_wen = 1'b0;
    logic [31:0] Bus_wdata = 32'h0;
    logic [31:0] Bus_rdata;
    logic [13:0] dram_addr;
    logic        dram_we;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata = DRAM_Q;
    logic [23:0] sw = 24'h0;
    logic [4:0]  btn = 5'h0;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  dig_seg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  seg_tab [16];

    bus_bridge #(.SCAN_DIV(2), .TDIV_RST(32'h0)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .Bus_addr(Bus_addr), .Bus_wen(Bus_wen), .Bus_wdata(Bus_wdata), .Bus_rdata(Bus_rdata),
        .dram_addr(dram_addr), .dram_we(dram_we), .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
        .sw(sw), .btn(btn), .led(led), .dig_en(dig_en), .dig_seg(dig_seg)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Expected load value goes onto the scoreboard, then is popped against Bus_rdata
    task automatic load_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        exp_q.push_back(exp);
        Bus_addr = addr;
        Bus_wen  = 1'b0;
        #1;
        check_eq(tag, Bus_rdata, exp_q.pop_front());
    endtask

    // Called away from a clock edge; the write lands on the next rising edge
    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        Bus_addr  = addr;
        Bus_wdata = data;
        Bus_wen   = 1'b1;
        @(posedge cpu_clk);
        #1;
        Bus_wen = 1'b0;
    endtask

    initial begin
        logic [7:0] prev_en;
        bit         found;
        int         dig_idx;
        seg_tab = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

        // Reset state
        repeat (2) @(posedge cpu_clk);
        #1;
        check_eq("rst_led", {8'h0, led}, 32'h0);
        check_eq("rst_dig_en", {24'h0, dig_en}, 32'hFE);
        check_eq("rst_dig_seg", {24'h0, dig_seg}, 32'h03);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        #1;

        // DRAM store
        Bus_addr = 32'h0000_0010; Bus_wdata = 32'hDEAD_BEEF; Bus_wen = 1'b1;
        #1;
        check_eq("dram_we", {31'h0, dram_we}, 32'h1);
        check_eq("dram_addr", {18'h0, dram_addr}, 32'h4);
        check_eq("dram_wdata", dram_wdata, 32'hDEAD_BEEF);
        @(posedge cpu_clk);
        #1;
        Bus_wen = 1'b0;
        load_check("dram_load", 32'h0000_0010, DRAM_Q);
        load_check("dig_untouched", A_DIG, 32'h0);
        load_check("led_untouched", A_LED, 32'h0);

        // LED store
        Bus_addr = A_LED; Bus_wdata = 32'h00A5_A5A5; Bus_wen = 1'b1;
        #1;
        check_eq("periph_dram_we", {31'h0, dram_we}, 32'h0);
        check_eq("led_before_edge", {8'h0, led}, 32'h0);
        @(posedge cpu_clk);
        #1;
        Bus_wen = 1'b0;
        check_eq("led_port", {8'h0, led}, 32'h00A5_A5A5);
        load_check("led_load", A_LED, 32'h00A5_A5A5);

        // Synchronisers, read-only and unmapped registers
        @(negedge cpu_clk);
        sw = 24'h123456; btn = 5'h15;
        load_check("sw_edge0", A_SW, 32'h0);
        @(posedge cpu_clk); #1;
        load_check("sw_edge1", A_SW, 32'h0);
        load_check("btn_edge1", A_BTN, 32'h0);
        @(posedge cpu_clk); #1;
        load_check("sw_edge2", A_SW, 32'h0012_3456);
        load_check("btn_edge2", A_BTN, 32'h15);
        load_check("unmapped", A_UNM, 32'h0);
        store(A_SW, 32'hFFFF_FFFF);
        load_check("sw_ro", A_SW, 32'h0012_3456);
        store(A_UNM, 32'hFFFF_FFFF);
        load_check("unmapped_wr", A_UNM, 32'h0);

        // Timer wrap with TDIV=3
        store(A_TDIV, 32'h3);
        store(A_TMR, 32'hFFFF_FFFE);
        repeat (3) @(posedge cpu_clk);
        #1;
        load_check("tmr_edge3", A_TMR, 32'hFFFF_FFFE);
        @(posedge cpu_clk); #1;
        load_check("tmr_edge4", A_TMR, 32'hFFFF_FFFF);
        repeat (4) @(posedge cpu_clk);
        #1;
        load_check("tmr_edge8", A_TMR, 32'h0);

        // TDIV=0 ticks every edge: TMR write coincides with a tick
        store(A_TDIV, 32'h0);
        store(A_TMR, 32'h0000_1234);
        load_check("tmr_wr_wins", A_TMR, 32'h0000_1234);
        @(posedge cpu_clk); #1;
        load_check("tmr_tick", A_TMR, 32'h0000_1235);
        store(A_TDIV, 32'h5);
        load_check("tdiv_keeps_tmr", A_TMR, 32'h0000_1235);
        load_check("tdiv_load", A_TDIV, 32'h5);

        // Scanner, SCAN_DIV=2
        store(A_DIG, 32'h0000_00A1);
        load_check("dig_load", A_DIG, 32'h0000_00A1);
        @(negedge cpu_clk);
        prev_en = dig_en;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge cpu_clk);
            if (dig_en == 8'hFE && prev_en == 8'h7F) found = 1'b1;
            else prev_en = dig_en;
        end
        check_eq("scan_wrap_seen", {31'h0, found}, 32'h1);
        for (int k = 0; k < 17; k++) begin
            dig_idx = (k / 2) % 8;
            exp_q.push_back({16'h0, ~(8'h1 << dig_idx),
                             seg_tab[(32'h0000_00A1 >> (4 * dig_idx)) & 32'hF]});
            #1;
            check_eq($sformatf("scan_%0d", k), {16'h0, dig_en, dig_seg}, exp_q.pop_front());
            @(negedge cpu_clk);
        end

        // Asynchronous reset mid-scan, then release
        repeat (3) @(posedge cpu_clk);
        #2;
        cpu_rst = 1'b1;
        #1;
        check_eq("async_led", {8'h0, led}, 32'h0);
        check_eq("async_dig_en", {24'h0, dig_en}, 32'hFE);
        check_eq("async_dig_seg", {24'h0, dig_seg}, 32'h03);
        load_check("async_tmr", A_TMR, 32'h0);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        load_check("rel_tmr", A_TMR, 32'h0);
        @(posedge cpu_clk); #1;
        load_check("rel_tmr_first", A_TMR, 32'h1);
        check_eq("rel_scan1", {24'h0, dig_en}, 32'hFE);
        @(posedge cpu_clk); #1;
        check_eq("rel_scan2", {24'h0, dig_en}, 32'hFD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
